// File: rtl/stage_pkg.sv
// Shared definitions for the stage-data ROM reader and the stage/object builder.
// Holds the end-marker value, default block geometry, word layout and FSM states.
package stage_pkg;

  localparam int STAGE_WL = 6;
  localparam int STAGE_SW = 3;
  localparam logic [31:0] END_MARK = 32'hFFFF_FFFF;

  // Object description as the builder decodes a non-marker stage word.
  typedef struct packed {
    logic [7:0] kind;
    logic [7:0] pos_x;
    logic [7:0] pos_y;
    logic [7:0] arg;
  } stage_word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/stage_fifo2.sv
// Two-entry output FIFO carrying stage word, word index and last tag.
// set_last tags the newest entry after the fact, unless that entry leaves this cycle.
module stage_fifo2 #(
  parameter int DW = 32,
  parameter int WL = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic [WL-1:0] push_index,
  input  logic          push_last,
  input  logic          pop,
  input  logic          set_last,
  output logic          valid,
  output logic [DW-1:0] head_data,
  output logic [WL-1:0] head_index,
  output logic          head_last,
  output logic [1:0]    count
);

  logic [DW-1:0] data_q  [2];
  logic [WL-1:0] index_q [2];
  logic [1:0]    last_q;
  logic          rd_ptr;
  logic          wr_ptr;
  logic          tag_tail;

  // The tail survives this cycle only if it is not also the head being popped.
  assign tag_tail = set_last && ((count == 2'd2) || ((count == 2'd1) && !pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i]  <= '0;
        index_q[i] <= '0;
      end
      last_q <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_ptr]  <= push_data;
        index_q[wr_ptr] <= push_index;
        last_q[wr_ptr]  <= push_last;
        wr_ptr          <= ~wr_ptr;
      end
      if (tag_tail) last_q[~wr_ptr] <= 1'b1;
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign valid      = (count != 2'd0);
  assign head_data  = data_q[rd_ptr];
  assign head_index = index_q[rd_ptr];
  assign head_last  = last_q[rd_ptr];

endmodule

// File: rtl/stage_reader.sv
// Streams one stage block out of the 1-cycle-latency stage ROM onto a valid/ready
// port, stopping at the end marker or the last word of the block.
module stage_reader
  import stage_pkg::*;
#(
  parameter int AW = 9,
  parameter int DW = 32,
  parameter int WL = STAGE_WL,
  parameter int SW = STAGE_SW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [SW-1:0] stage,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [WL-1:0] out_index,
  output logic          out_last
);

  state_t        state;
  state_t        state_next;
  logic          vld_p1;
  logic [WL-1:0] idx_p1;
  logic          fetched_all;
  logic [1:0]    count;
  logic          head_last;
  logic          pop;
  logic          is_mark;
  logic          push;
  logic          last_word;
  logic          issue;
  logic [2:0]    credit;

  assign pop       = out_valid & out_ready;
  assign is_mark   = (state == S_FETCH) && vld_p1 && (&rom_data);
  assign push      = (state == S_FETCH) && vld_p1 && !(&rom_data);
  assign last_word = push && (idx_p1 == '1);

  // Occupancy after this cycle's pop and push; a new read needs a free slot beyond it.
  assign credit = {1'b0, count} - {2'b00, pop} + {2'b00, vld_p1};
  assign issue  = (state == S_FETCH) && !fetched_all && !is_mark && (credit < 3'd2);

  // A marker arriving while its predecessor is the head tags that word immediately.
  assign out_last = head_last | (is_mark && (count == 2'd1));
  assign busy     = (state == S_FETCH) || (state == S_DRAIN);
  assign done     = (state == S_DONE);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_FETCH;
      S_FETCH: if (is_mark || last_word) state_next = S_DRAIN;
      S_DRAIN: if ((count == 2'd0) || ((count == 2'd1) && pop)) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // _p1: a read was taken from rom_addr last edge; its word is on rom_data now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rom_addr    <= '0;
      vld_p1      <= 1'b0;
      idx_p1      <= '0;
      fetched_all <= 1'b0;
    end else begin
      state  <= state_next;
      vld_p1 <= issue;
      if ((state == S_IDLE) && start) begin
        rom_addr    <= {stage, {WL{1'b0}}};
        fetched_all <= 1'b0;
      end else if (issue) begin
        idx_p1 <= rom_addr[WL-1:0];
        if (&rom_addr[WL-1:0]) fetched_all <= 1'b1;
        else                   rom_addr    <= rom_addr + AW'(1);
      end
    end
  end

  stage_fifo2 #(
    .DW(DW),
    .WL(WL)
  ) fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (rom_data),
    .push_index(idx_p1),
    .push_last (last_word),
    .pop       (pop),
    .set_last  (is_mark),
    .valid     (out_valid),
    .head_data (out_data),
    .head_index(out_index),
    .head_last (head_last),
    .count     (count)
  );

endmodule
